control_path: RTL and testbench

CONTROL_PATH -- requirements
Module: control_path

---
 rtl/control_path.sv | 132 +++++++++++++
 tb/tb_control_path.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_path.sv
// Rice-decoder control FSM: sequences load, unary, binary, store steps.
// Optional CP_KZERO_SKIP_EN: k==0 skips the binary phase.
module control_path (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [5:0] j,
  input  logic [4:0] k,
  input  logic       c1zero,
  input  logic       c2zero,
  input  logic       cout,
  output logic       ldin,
  output logic       ldor,
  output logic       peen
);

  typedef enum logic [3:0] {
    S0_IDLE,
    S1_LOAD,
    S2_CHECK,
    S3_UNARY,
    S4_REFILL_U,
    S5_REFILL_B,
    S6_BINARY,
    S7_STORE,
    S8_DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [5:0] cnt;
  logic [5:0] cnt_nx;
  logic [5:0] cnt_inc;
  logic       active;
  logic       unary_to_store;

`ifdef CP_KZERO_SKIP_EN
  assign unary_to_store = (k == 5'd0);
`else
  logic k_unused;
  assign k_unused       = ^k;
  assign unary_to_store = 1'b0;
`endif

  assign cnt_inc = cnt + 6'd1;

  // S0 and S8 are the only states that ignore stop
  assign active = (state != S0_IDLE) &&
                  (state != S8_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S0_IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ldin     = 1'b0;
    ldor     = 1'b0;
    peen     = 1'b0;
    unique case (state)
      S0_IDLE: begin
        if (start)
          state_nx = S1_LOAD;
      end
      S1_LOAD: begin
        ldin     = 1'b1;
        cnt_nx   = 6'd0;
        state_nx = S2_CHECK;
      end
      S2_CHECK: begin
        if (j == 6'd0)
          state_nx = S8_DONE;
        else
          state_nx = S3_UNARY;
      end
      S3_UNARY: begin
        peen = 1'b1;
        if (c1zero) begin
          if (unary_to_store)
            state_nx = S7_STORE;
          else
            state_nx = S6_BINARY;
        end else if (cout) begin
          state_nx = S4_REFILL_U;
        end
      end
      S4_REFILL_U: begin
        ldin     = 1'b1;
        state_nx = S3_UNARY;
      end
      S5_REFILL_B: begin
        ldin     = 1'b1;
        state_nx = S6_BINARY;
      end
      S6_BINARY: begin
        peen = 1'b1;
        if (c2zero)
          state_nx = S7_STORE;
        else if (cout)
          state_nx = S5_REFILL_B;
      end
      S7_STORE: begin
        ldor   = 1'b1;
        cnt_nx = cnt_inc;
        if (cnt_inc == j)
          state_nx = S8_DONE;
        else if (cout)
          state_nx = S4_REFILL_U;
        else
          state_nx = S3_UNARY;
      end
      S8_DONE: begin
        if (!start && !stop)
          state_nx = S0_IDLE;
      end
      default: begin
        state_nx = S0_IDLE;
      end
    endcase
    if (stop && active)
      state_nx = S8_DONE;
  end

endmodule

// File: tb/tb_control_path.sv
// Self-checking bench for control_path: directed table
// plus randomized run against a behavioural model.
module tb_control_path;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic [5:0] j;
  logic [4:0] k;
  logic       c1zero;
  logic       c2zero;
  logic       cout;
  logic       ldin;
  logic       ldor;
  logic       peen;

  int errors;
  int checks;

  control_path dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .j      (j),
    .k      (k),
    .c1zero (c1zero),
    .c2zero (c2zero),
    .cout   (cout),
    .ldin   (ldin),
    .ldor   (ldor),
    .peen   (peen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r;
    logic       s;
    logic       sp;
    logic [5:0] jj;
    logic [4:0] kk;
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] e;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model phases
  localparam int IDLE  = 0;
  localparam int LOAD  = 1;
  localparam int CHECK = 2;
  localparam int UNARY = 3;
  localparam int REF_U = 4;
  localparam int REF_B = 5;
  localparam int BIN   = 6;
  localparam int STORE = 7;
  localparam int DONE  = 8;

  int  m_ph;
  int  m_cnt;
  bit  skip_en;

  function automatic logic [2:0] m_out(int ph);
    logic [2:0] o;
    o = 3'b000;
    if (ph == LOAD || ph == REF_U || ph == REF_B)
      o = 3'b100;
    if (ph == STORE)
      o = 3'b010;
    if (ph == UNARY || ph == BIN)
      o = 3'b001;
    return o;
  endfunction

  task automatic model_step();
    int nx;
    nx = m_ph;
    if (!reset) begin
      m_ph  = IDLE;
      m_cnt = 0;
      return;
    end
    case (m_ph)
      IDLE:  if (start) nx = LOAD;
      LOAD: begin
        m_cnt = 0;
        nx    = CHECK;
      end
      CHECK: nx = (j == 0) ? DONE : UNARY;
      UNARY: begin
        if (c1zero)
          nx = (skip_en && k == 0) ? STORE : BIN;
        else if (cout)
          nx = REF_U;
      end
      REF_U: nx = UNARY;
      REF_B: nx = BIN;
      BIN: begin
        if (c2zero)      nx = STORE;
        else if (cout)   nx = REF_B;
      end
      STORE: begin
        m_cnt = (m_cnt + 1) % 64;
        if (m_cnt == int'(j)) nx = DONE;
        else if (cout)        nx = REF_U;
        else                  nx = UNARY;
      end
      DONE: if (!start && !stop) nx = IDLE;
      default: nx = IDLE;
    endcase
    if (stop && m_ph >= LOAD && m_ph <= STORE)
      nx = DONE;
    m_ph = nx;
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic sp,
                     input logic [5:0] jj,
                     input logic [4:0] kk,
                     input logic a, input logic b,
                     input logic c);
    @(negedge clk);
    reset  = r;
    start  = s;
    stop   = sp;
    j      = jj;
    k      = kk;
    c1zero = a;
    c2zero = b;
    cout   = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [2:0] want);
    logic [2:0] got;
    got = {ldin, ldor, peen};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got ldin/ldor/peen=%b want %b",
               nm, got, want);
    end
  endtask

  task automatic add(input string nm, input logic r,
                     input logic s, input logic sp,
                     input logic [5:0] jj,
                     input logic [4:0] kk,
                     input logic a, input logic b,
                     input logic c,
                     input logic [2:0] e);
    vec_t v;
    v.name = nm; v.r = r; v.s = s; v.sp = sp;
    v.jj = jj; v.kk = kk;
    v.a = a; v.b = b; v.c = c; v.e = e;
    tbl.push_back(v);
  endtask

  localparam logic [2:0] O0 = 3'b000;
  localparam logic [2:0] OI = 3'b100;
  localparam logic [2:0] OR = 3'b010;
  localparam logic [2:0] OP = 3'b001;

  initial begin
    logic r, s, sp, a, b, c;
    logic [5:0] rj;
    logic [4:0] rk;
    errors  = 0;
    checks  = 0;
    m_ph    = IDLE;
    m_cnt   = 0;
`ifdef CP_KZERO_SKIP_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    reset = 0; start = 0; stop = 0; j = 0; k = 0;
    c1zero = 0; c2zero = 0; cout = 0;

    add("rst0",      0,1,0, 3,3, 0,0,0, O0);
    add("rst1",      0,1,0, 3,3, 0,0,0, O0);
    add("load",      1,1,0, 3,3, 0,0,0, OI);
    add("check",     1,0,0, 3,3, 0,0,0, O0);
    add("unary",     1,0,0, 3,3, 0,0,0, OP);
    add("unary_hold",1,0,0, 3,3, 0,0,0, OP);
    add("refill_u",  1,0,0, 3,3, 0,0,1, OI);
    add("back_u",    1,0,0, 3,3, 0,0,0, OP);
    add("to_bin",    1,0,0, 3,3, 1,0,0, OP);
    add("refill_b",  1,0,0, 3,3, 0,0,1, OI);
    add("back_b",    1,0,0, 3,3, 0,0,0, OP);
    add("c2_prio",   1,0,0, 3,3, 0,1,1, OR);
    add("st_refill", 1,0,0, 3,3, 0,0,1, OI);
    add("u2",        1,0,0, 3,3, 0,0,0, OP);
    add("b2",        1,0,0, 3,3, 1,0,1, OP);
    add("store2",    1,0,0, 3,3, 0,1,0, OR);
    add("u3",        1,0,0, 3,3, 0,0,0, OP);
    add("stop_mid",  1,0,1, 3,3, 0,0,0, O0);
    add("done_hold", 1,1,0, 3,3, 0,0,0, O0);
    add("to_idle",   1,0,0, 3,3, 0,0,0, O0);
    add("idle_stop", 1,0,1, 3,3, 0,0,0, O0);
    add("reload",    1,1,0, 3,3, 0,0,0, OI);
    add("chk_b",     1,0,0, 3,3, 0,0,0, O0);
    add("u_b1",      1,0,0, 3,3, 1,1,0, OP);
    add("bin_b1",    1,0,0, 3,3, 1,1,0, OP);
    add("st_b1",     1,0,0, 3,3, 1,1,0, OR);
    add("u_b2",      1,0,0, 3,3, 1,1,0, OP);
    add("bin_b2",    1,0,0, 3,3, 1,1,0, OP);
    add("st_b2",     1,0,0, 3,3, 1,1,0, OR);
    add("u_b3",      1,0,0, 3,3, 1,1,0, OP);
    add("bin_b3",    1,0,0, 3,3, 1,1,0, OP);
    add("st_b3",     1,0,0, 3,3, 1,1,0, OR);
    add("done3",     1,1,0, 3,3, 1,1,0, O0);
    add("done3_hold",1,1,0, 3,3, 1,1,0, O0);
    add("idle_j0",   1,0,0, 0,3, 0,0,0, O0);
    add("load_j0",   1,1,0, 0,3, 0,0,0, OI);
    add("chk_j0",    1,0,0, 0,3, 0,0,0, O0);
    add("done_j0",   1,0,0, 0,3, 0,0,0, O0);
    add("idle2",     1,0,0, 0,3, 0,0,0, O0);
    add("load_k0",   1,1,0, 2,0, 0,0,0, OI);
    add("chk_k0",    1,0,0, 2,0, 0,0,0, O0);
    add("u_k0",      1,0,0, 2,0, 0,0,0, OP);
`ifdef CP_KZERO_SKIP_EN
    add("k0_skip",   1,0,0, 2,0, 1,0,0, OR);
    add("k0_after",  1,0,0, 2,0, 0,1,0, OP);
`else
    add("k0_bin",    1,0,0, 2,0, 1,0,0, OP);
    add("k0_store",  1,0,0, 2,0, 0,1,0, OR);
`endif
    add("rst_mid",   0,0,0, 2,0, 0,0,0, O0);
    add("rst_ovr",   0,1,1, 2,0, 0,0,0, O0);
    add("post_rst",  1,0,0, 2,0, 0,0,0, O0);
    add("post_rst2", 1,0,0, 2,0, 0,0,0, O0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].jj,
          tbl[i].kk, tbl[i].a, tbl[i].b, tbl[i].c);
      check(tbl[i].name, tbl[i].e);
    end

    rj = 6'd3;
    rk = 5'd1;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(63) != 0);
      s  = ($urandom_range(2) == 0);
      sp = ($urandom_range(19) == 0);
      a  = ($urandom_range(3) == 0);
      b  = ($urandom_range(3) == 0);
      c  = ($urandom_range(2) == 0);
      if (m_ph == IDLE) begin
        rj = 6'($urandom_range(5));
        rk = 5'($urandom_range(2));
      end
      cyc(r, s, sp, rj, rk, a, b, c);
      check("random", m_out(m_ph));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
